// File: rtl/cnu_serial_pkg.sv
// cnu_serial_pkg: widths, state encodings and arithmetic helpers for the serial check-node unit
package cnu_serial_pkg;
  localparam int D      = 8;
  localparam int RES_W  = 8;
  localparam int EXT_W  = 3;
  localparam int IDX_W  = 3;
  localparam int DATA_W = RES_W + EXT_W;
  localparam int MAG_W  = DATA_W - 1;
  localparam int SW     = DATA_W + 2;
  localparam logic [MAG_W-1:0] MAG_ONES = '1;
  localparam logic [IDX_W:0]   DEG_MIN  = (IDX_W+1)'(2);
  localparam logic [IDX_W:0]   DEG_MAX  = (IDX_W+1)'(D);
  typedef logic signed [SW-1:0] sw_t;
  localparam sw_t R_MAX = sw_t'(2**(RES_W-1) - 1);
  typedef enum logic {C_RUN, C_WAIT} c_state_e;
  typedef enum logic {E_EMPTY, E_BUSY} e_state_e;
  typedef struct packed {
    logic [MAG_W-1:0] m1;
    logic [MAG_W-1:0] m2;
    logic [IDX_W-1:0] idx;
    logic             par;
  } summ_t;
  // |x| with the most negative value folded onto the largest magnitude
  function automatic logic [MAG_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
    logic [DATA_W-1:0] a;
    a = x[DATA_W-1] ? -x : x;
    return a[DATA_W-1] ? MAG_ONES : a[MAG_W-1:0];
  endfunction
  // Symmetric clamp to +/-(2^(RES_W-1)-1)
  function automatic logic [RES_W-1:0] sat_sym(input sw_t x);
    sw_t y;
    y = x > R_MAX ? R_MAX : x < -R_MAX ? -R_MAX : x;
    return y[RES_W-1:0];
  endfunction
  // Normalized min-sum: floor(3*m/4)
  function automatic sw_t scale34(input logic [MAG_W-1:0] m);
    logic [SW-1:0] u;
    u = SW'(m);
    return sw_t'((u + (u << 1)) >> 2);
  endfunction
endpackage

// File: rtl/cnu_serial_minsel.sv
// cnu_serial_minsel: combinational min/min2/index/parity update for one incoming message
module cnu_serial_minsel
  import cnu_serial_pkg::*;
(
  input  logic [MAG_W-1:0] mag,
  input  logic             sgn,
  input  logic [IDX_W-1:0] cnt,
  input  logic [MAG_W-1:0] m1_i,
  input  logic [MAG_W-1:0] m2_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             par_i,
  output logic [MAG_W-1:0] m1_o,
  output logic [MAG_W-1:0] m2_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             par_o
);
  logic first;
  logic lt_m1;
  logic lt_m2;
  assign first = cnt == '0;
  assign lt_m1 = mag < m1_i;
  assign lt_m2 = mag < m2_i;
  // First message seeds the summary; strict compares keep the earliest index on ties
  always_comb begin
    m1_o  = first || lt_m1 ? mag : m1_i;
    m2_o  = first ? MAG_ONES : lt_m1 ? m1_i : lt_m2 ? mag : m2_i;
    idx_o = first ? '0 : lt_m1 ? cnt : idx_i;
    par_o = first ? sgn : par_i ^ sgn;
  end
endmodule

// File: rtl/cnu_serial.sv
// cnu_serial: serial variable-degree min-sum check-node unit; CNU_OFFSET_EN adds offset-min-sum mode
module cnu_serial
  import cnu_serial_pkg::*;
#(
  parameter int OFFSET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [IDX_W:0]    deg,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  r,
  output logic [IDX_W-1:0]  r_idx,
  output logic              r_last
);
  c_state_e         c_state_q, c_state_d;
  e_state_e         e_state_q, e_state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d, ridx_q, ridx_d;
  logic [IDX_W:0]   degc_q, degc_d, dege_q, dege_d, deg_cl, deg_cur;
  summ_t            sum_q, sum_d, sume_q, sume_d, sum_upd;
  logic [D-1:0]     sgn_q, sgn_d, sgne_q, sgne_d, sgn_upd;
  logic [MAG_W-1:0] mag, m;
  logic             sgn_in, acc, rd, drain, last_acc, bank_free, xfer;
  sw_t              t, sv;

  assign mag       = abs_sat(q);
  assign sgn_in    = q[DATA_W-1];
  assign deg_cl    = (deg < DEG_MIN || deg > DEG_MAX) ? DEG_MAX : deg;
  assign deg_cur   = cnt_q == '0 ? deg_cl : degc_q;
  assign in_ready  = en && c_state_q == C_RUN;
  assign out_valid = en && e_state_q == E_BUSY;
  assign r_idx     = ridx_q;
  assign r_last    = {1'b0, ridx_q} == dege_q - 1'b1;
  assign acc       = in_valid && in_ready;
  assign rd        = out_valid && out_ready;
  assign drain     = rd && r_last;
  assign last_acc  = acc && {1'b0, cnt_q} == deg_cur - 1'b1;
  assign bank_free = e_state_q == E_EMPTY || drain;
  assign xfer      = en && bank_free && (last_acc || c_state_q == C_WAIT);
  assign sgn_upd   = (cnt_q == '0 ? '0 : sgn_q) | (D'(sgn_in) << cnt_q);

  cnu_serial_minsel u_minsel (
    .mag   (mag),
    .sgn   (sgn_in),
    .cnt   (cnt_q),
    .m1_i  (sum_q.m1),
    .m2_i  (sum_q.m2),
    .idx_i (sum_q.idx),
    .par_i (sum_q.par),
    .m1_o  (sum_upd.m1),
    .m2_o  (sum_upd.m2),
    .idx_o (sum_upd.idx),
    .par_o (sum_upd.par)
  );

  // Collector: fold accepted q into the summary, park in C_WAIT while the emit bank is busy
  always_comb begin
    sum_d     = acc ? sum_upd : sum_q;
    sgn_d     = acc ? sgn_upd : sgn_q;
    degc_d    = (acc && cnt_q == '0) ? deg_cl : degc_q;
    cnt_d     = xfer ? '0 : (acc && !last_acc) ? cnt_q + 1'b1 : cnt_q;
    c_state_d = xfer ? C_RUN : last_acc ? C_WAIT : c_state_q;
  end

  // Emitter: load a finished row on transfer, step r_idx per handshake, free after r_last
  always_comb begin
    sume_d    = xfer ? sum_d : sume_q;
    sgne_d    = xfer ? sgn_d : sgne_q;
    dege_d    = xfer ? deg_cur : dege_q;
    e_state_d = xfer ? E_BUSY : drain ? E_EMPTY : e_state_q;
    ridx_d    = (xfer || drain) ? '0 : rd ? ridx_q + 1'b1 : ridx_q;
  end

`ifdef CNU_OFFSET_EN
  // Output magnitude: offset-min-sum when mode is set, else normalized x3/4
  always_comb begin
    m = ridx_q == sume_q.idx ? sume_q.m2 : sume_q.m1;
    t = mode ? (m > MAG_W'(OFFSET) ? sw_t'(m - MAG_W'(OFFSET)) : '0) : scale34(m);
  end
`else
  logic unused_mode;
  assign unused_mode = mode ^ (OFFSET < 0);
  // Output magnitude: normalized x3/4 of min, or min2 at the minimum's own position
  always_comb begin
    m = ridx_q == sume_q.idx ? sume_q.m2 : sume_q.m1;
    t = scale34(m);
  end
`endif

  // Apply extrinsic sign and clamp symmetrically
  always_comb begin
    sv = (sume_q.par ^ sgne_q[ridx_q]) ? -t : t;
    r  = sat_sym(sv);
  end

  // State registers; en=0 holds everything because no handshake or transfer can fire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_state_q <= C_RUN;
      e_state_q <= E_EMPTY;
      cnt_q     <= '0;
      ridx_q    <= '0;
      degc_q    <= '0;
      dege_q    <= '0;
      sum_q     <= '0;
      sume_q    <= '0;
      sgn_q     <= '0;
      sgne_q    <= '0;
    end else begin
      c_state_q <= c_state_d;
      e_state_q <= e_state_d;
      cnt_q     <= cnt_d;
      ridx_q    <= ridx_d;
      degc_q    <= degc_d;
      dege_q    <= dege_d;
      sum_q     <= sum_d;
      sume_q    <= sume_d;
      sgn_q     <= sgn_d;
      sgne_q    <= sgne_d;
    end
  end
endmodule

// File: tb/tb_cnu_serial.sv
// tb_cnu_serial: randomized and directed checks of cnu_serial against a row-level min-sum model
module tb_cnu_serial;
  localparam int OFF = 1;
  logic        clk = 1'b0;
  logic        rst, en, mode, in_valid, in_ready, out_valid, out_ready, r_last;
  logic [3:0]  deg;
  logic [10:0] q;
  logic [7:0]  r;
  logic [2:0]  r_idx;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [10:0] tx_q[$];
  logic [3:0]  tx_d[$];
  int row[$];
  int exp_r[$], exp_i[$], exp_l[$];
  int got_r[$], got_i[$], got_l[$], got_c[$];
  int acc_c[$];

  cnu_serial dut (
    .clk(clk), .rst(rst), .en(en), .deg(deg), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .q(q),
    .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .r_idx(r_idx), .r_last(r_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int dclamp(input int d);
    return (d < 2 || d > 8) ? 8 : d;
  endfunction

  function automatic int rnd_val();
    int k;
    int e[4];
    e = '{-1024, 1023, 0, -1};
    k = int'($urandom_range(3));
    if (k == 0) return int'($urandom_range(40)) - 20;
    if (k == 1) return int'($urandom_range(2047)) - 1024;
    if (k == 2) return e[$urandom_range(3)];
    return int'($urandom_range(600)) - 300;
  endfunction

  function automatic int t_of(input int m);
`ifdef CNU_OFFSET_EN
    if (mode) return m > OFF ? m - OFF : 0;
`endif
    return (3 * m) / 4;
  endfunction

  // Queue a row for transmission and record the r values the min-sum rules predict
  function automatic void add_row(input int d_in);
    int d, mi, m2, par, m, t, v, s;
    int mg[8];
    int sg[8];
    d = dclamp(d_in);
    par = 0;
    for (int i = 0; i < d; i++) begin
      tx_q.push_back(11'(row[i]));
      tx_d.push_back(4'(d_in));
      sg[i] = row[i] < 0 ? 1 : 0;
      mg[i] = row[i] == -1024 ? 1023 : (row[i] < 0 ? -row[i] : row[i]);
      par ^= sg[i];
    end
    mi = 0;
    for (int i = 0; i < d; i++) if (mg[i] < mg[mi]) mi = i;
    m2 = 1023;
    for (int i = 0; i < d; i++) if (i != mi && mg[i] < m2) m2 = mg[i];
    for (int j = 0; j < d; j++) begin
      m = j == mi ? m2 : mg[mi];
      t = t_of(m);
      s = par ^ sg[j];
      v = s ? -t : t;
      v = v > 127 ? 127 : v < -127 ? -127 : v;
      exp_r.push_back(v);
      exp_i.push_back(j);
      exp_l.push_back(j == d - 1 ? 1 : 0);
    end
    row.delete();
  endfunction

  function automatic void clear_all();
    tx_q.delete(); tx_d.delete(); row.delete();
    exp_r.delete(); exp_i.delete(); exp_l.delete();
    got_r.delete(); got_i.delete(); got_l.delete(); got_c.delete();
    acc_c.delete();
  endfunction

  task automatic send_all(input int gap_pct);
    int n;
    while (tx_q.size() > 0) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        continue;
      end
      in_valid = 1'b1; q = tx_q[0]; deg = tx_d[0];
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 300) begin @(negedge clk); n++; end
      if (n >= 300) begin
        checks++; errors++;
        $display("FAIL send_timeout in_ready stayed low, %0d q left", tx_q.size());
        tx_q.delete(); tx_d.delete();
        break;
      end
      acc_c.push_back(cyc);
      @(posedge clk); #1;
      void'(tx_q.pop_front());
      void'(tx_d.pop_front());
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int n, input int stall_pct);
    int waited;
    waited = 0;
    while (got_r.size() < n && waited < 5000) begin
      out_ready = int'($urandom_range(99)) >= stall_pct;
      @(negedge clk);
      if (out_valid && out_ready) begin
        got_r.push_back(int'($signed(r)));
        got_i.push_back(int'(r_idx));
        got_l.push_back(int'(r_last));
        got_c.push_back(cyc);
      end
      @(posedge clk); #1;
      waited++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0; q = '0; deg = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (r !== 8'd0) begin errors++; $display("FAIL reset_r got=%0d want=0", r); end
    checks++; if (r_idx !== 3'd0) begin errors++; $display("FAIL reset_r_idx got=%0d want=0", r_idx); end
    checks++; if (r_last !== 1'b0) begin errors++; $display("FAIL reset_r_last got=%b want=0", r_last); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    int ev[9], ei[9], el[9];
    ev = '{-3, 3, -6, -3, -5, -5, 5, -127, -127};
    ei = '{0, 1, 2, 3, 0, 1, 2, 0, 1};
    el = '{0, 0, 0, 1, 0, 0, 1, 0, 1};
    clear_all();
    mode = 1'b0;
    row = '{20, -8, 5, 12};   add_row(4);
    row = '{7, 7, -7};        add_row(3);
    row = '{-1024, -1024};    add_row(2);
    fork
      send_all(0);
      collect(9, 0);
    join
    checks++; if (got_r.size() != 9) begin errors++; $display("FAIL dir_count got=%0d want=9", got_r.size()); end
    for (int i = 0; i < 9 && i < got_r.size(); i++) begin
      checks++;
      if (got_r[i] !== ev[i] || got_i[i] !== ei[i] || got_l[i] !== el[i]) begin
        errors++;
        $display("FAIL dir_r[%0d] got r=%0d idx=%0d last=%0d want r=%0d idx=%0d last=%0d",
                 i, got_r[i], got_i[i], got_l[i], ev[i], ei[i], el[i]);
      end
    end
    if (acc_c.size() == 9 && got_c.size() == 9) begin
      checks++;
      if (got_c[0] !== acc_c[3] + 1) begin errors++; $display("FAIL dir_latency got=%0d want=%0d", got_c[0] - acc_c[3], 1); end
      checks++;
      if (acc_c[7] !== acc_c[6] + 2) begin errors++; $display("FAIL dir_wait_gap got=%0d want=2", acc_c[7] - acc_c[6]); end
      for (int i = 1; i < 9; i++) begin
        checks++;
        if (got_c[i] !== got_c[i-1] + 1) begin errors++; $display("FAIL dir_no_bubble[%0d] got gap=%0d want=1", i, got_c[i] - got_c[i-1]); end
      end
    end
  endtask

  task automatic test_backpressure;
    int ev[4], ei[4];
    ev = '{-6, 2, 4, -3};
    ei = '{0, 1, 0, 1};
    clear_all();
    out_ready = 1'b0;
    row = '{3, -9};  add_row(2);
    row = '{-4, 6};  add_row(2);
    send_all(0);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_blocked got=%b want=0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got=%b want=1", out_valid); end
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_held got=%b want=0", in_ready); end
    @(posedge clk); #1;
    collect(4, 0);
    checks++; if (got_r.size() != 4) begin errors++; $display("FAIL bp_count got=%0d want=4", got_r.size()); end
    for (int i = 0; i < 4 && i < got_r.size(); i++) begin
      checks++;
      if (got_r[i] !== ev[i] || got_i[i] !== ei[i] || got_l[i] !== ei[i]) begin
        errors++;
        $display("FAIL bp_r[%0d] got r=%0d idx=%0d last=%0d want r=%0d idx=%0d last=%0d",
                 i, got_r[i], got_i[i], got_l[i], ev[i], ei[i], ei[i]);
      end
      if (i > 0) begin
        checks++;
        if (got_c[i] !== got_c[i-1] + 1) begin errors++; $display("FAIL bp_no_bubble[%0d] got gap=%0d want=1", i, got_c[i] - got_c[i-1]); end
      end
    end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_back got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_out_valid got=%b want=0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_enable;
    logic [7:0] r_s;
    logic [2:0] i_s;
    clear_all();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) row.push_back(rnd_val());
    add_row(5);
    send_all(0);
    collect(2, 0);
    for (int i = 0; i < 2 && i < got_r.size(); i++) begin
      checks++;
      if (got_r[i] !== exp_r[i] || got_i[i] !== exp_i[i]) begin
        errors++; $display("FAIL en_pre[%0d] got r=%0d idx=%0d want r=%0d idx=%0d", i, got_r[i], got_i[i], exp_r[i], exp_i[i]);
      end
    end
    @(negedge clk);
    r_s = r; i_s = r_idx;
    @(posedge clk); #1;
    en = 1'b0; in_valid = 1'b1; q = 11'd5; deg = 4'd2; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL en_in_ready[%0d] got=%b want=0", k, in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL en_out_valid[%0d] got=%b want=0", k, out_valid); end
      checks++; if (r !== r_s || r_idx !== i_s) begin errors++; $display("FAIL en_hold[%0d] got r=%0d idx=%0d want r=%0d idx=%0d", k, r, r_idx, r_s, i_s); end
    end
    @(posedge clk); #1;
    en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) begin void'(exp_r.pop_front()); void'(exp_i.pop_front()); void'(exp_l.pop_front()); end
    got_r.delete(); got_i.delete(); got_l.delete(); got_c.delete();
    for (int i = 0; i < 3; i++) row.push_back(rnd_val());
    add_row(3);
    fork
      send_all(0);
      collect(6, 0);
    join
    checks++; if (got_r.size() != 6) begin errors++; $display("FAIL en_count got=%0d want=6", got_r.size()); end
    for (int i = 0; i < 6 && i < got_r.size(); i++) begin
      checks++;
      if (got_r[i] !== exp_r[i] || got_i[i] !== exp_i[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL en_post[%0d] got r=%0d idx=%0d last=%0d want r=%0d idx=%0d last=%0d",
                 i, got_r[i], got_i[i], got_l[i], exp_r[i], exp_i[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    clear_all();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) row.push_back(rnd_val());
    add_row(3);
    send_all(0);
    tx_q.push_back(11'(rnd_val())); tx_d.push_back(4'd4);
    tx_q.push_back(11'(rnd_val())); tx_d.push_back(4'd4);
    send_all(0);
    @(posedge clk); #3;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
    checks++; if (r_idx !== 3'd0 || r !== 8'd0) begin errors++; $display("FAIL rstmid_out got r=%0d idx=%0d want r=0 idx=0", r, r_idx); end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_all();
    for (int i = 0; i < 4; i++) row.push_back(rnd_val());
    add_row(4);
    fork
      send_all(20);
      collect(4, 20);
    join
    checks++; if (got_r.size() != 4) begin errors++; $display("FAIL rstmid_count got=%0d want=4", got_r.size()); end
    for (int i = 0; i < 4 && i < got_r.size(); i++) begin
      checks++;
      if (got_r[i] !== exp_r[i] || got_i[i] !== exp_i[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL rstmid_r[%0d] got r=%0d idx=%0d last=%0d want r=%0d idx=%0d last=%0d",
                 i, got_r[i], got_i[i], got_l[i], exp_r[i], exp_i[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_random;
    int d, total;
    clear_all();
    mode = 1'($urandom_range(1));
    for (int k = 0; k < 25; k++) begin
      d = int'($urandom_range(15));
      for (int i = 0; i < dclamp(d); i++) row.push_back(rnd_val());
      add_row(d);
    end
    total = exp_r.size();
    fork
      send_all(25);
      collect(total, 30);
    join
    checks++; if (got_r.size() != total) begin errors++; $display("FAIL rnd_count got=%0d want=%0d", got_r.size(), total); end
    for (int i = 0; i < total && i < got_r.size(); i++) begin
      checks++;
      if (got_r[i] !== exp_r[i] || got_i[i] !== exp_i[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL rnd_r[%0d] got r=%0d idx=%0d last=%0d want r=%0d idx=%0d last=%0d",
                 i, got_r[i], got_i[i], got_l[i], exp_r[i], exp_i[i], exp_l[i]);
      end
    end
    mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
